// File: rtl/af_arb_pkg.sv
// Shared types and field layout for the address-FIFO request arbiter.
// A command entry is {row, bank, col, rank, rw}; the row-locality key is {rank, row, bank}.
package af_arb_pkg;

  localparam int AF_W     = 27;
  localparam int ROW_LSB  = 13;
  localparam int ROW_W    = 14;
  localparam int BANK_LSB = 10;
  localparam int BANK_W   = 3;
  localparam int COL_LSB  = 2;
  localparam int COL_W    = 8;
  localparam int RANK_BIT = 1;
  localparam int RW_BIT   = 0;
  localparam int KEY_W    = 18;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Bursts stay within one open row: same rank, row and bank.
  function automatic logic [KEY_W-1:0] af_key(input logic [AF_W-1:0] cmd);
    return {cmd[RANK_BIT], cmd[ROW_LSB +: ROW_W], cmd[BANK_LSB +: BANK_W]};
  endfunction

endpackage

// File: rtl/af_req_arbiter_if.sv
// Requester-side handshake and address FIFO write port of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/FIFO side.
interface af_req_arbiter_if #(
  parameter int NREQ = 4
);
  import af_arb_pkg::*;

  logic [NREQ-1:0]      ReqValid;
  logic [AF_W*NREQ-1:0] ReqCmd;
  logic [NREQ-1:0]      ReqReady;
  logic [NREQ-1:0]      Grant;
  logic [AF_W-1:0]      AFWD;
  logic                 AFWEn;
  logic                 AFFull;
  logic                 Busy;

  modport slave (
    input  ReqValid, ReqCmd, AFFull,
    output ReqReady, Grant, AFWD, AFWEn, Busy
  );

  modport master (
    output ReqValid, ReqCmd, AFFull,
    input  ReqReady, Grant, AFWD, AFWEn, Busy
  );

endinterface

// File: rtl/af_req_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning ptr, ptr+1, ... modulo N.
// Purely combinational; index is only meaningful when any is high.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        index     = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/af_req_arbiter.sv
// Round-robin arbiter feeding the SODIMM address FIFO write port with bounded,
// row-local bursts. Single clock domain (WriteClk), synchronous active-high Reset.
module af_req_arbiter
  import af_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic            WriteClk,
  input  logic            Reset,
  af_req_arbiter_if.slave bus
);

  localparam int            IW         = $clog2(NREQ);
  localparam int            BW         = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);

  arb_state_e       r_state;
  logic [NREQ-1:0]  r_grant;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_rr_ptr;
  logic [BW-1:0]    r_burst_cnt;
  logic [KEY_W-1:0] r_last_key;
  logic [AF_W-1:0]  r_afwd;
  logic             r_afwen;

  logic [AF_W-1:0]  w_cmd [NREQ];
  logic [AF_W-1:0]  w_owner_cmd;
  logic             w_owner_valid;
  logic             w_row_break;
  logic             w_ready;
  logic             w_xfer;
  logic             w_release;
  logic [IW-1:0]    w_next_ptr;
  logic [NREQ-1:0]  w_pick_onehot;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_cmd
    assign w_cmd[g] = bus.ReqCmd[g*AF_W +: AF_W];
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (bus.ReqValid),
    .ptr    (r_rr_ptr),
    .onehot (w_pick_onehot),
    .index  (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_owner_cmd   = w_cmd[r_owner];
  assign w_owner_valid = bus.ReqValid[r_owner];
  assign w_row_break   = (r_burst_cnt != '0) && (af_key(w_owner_cmd) != r_last_key);

  // Ready is withheld while Reset is sampled so that nothing is accepted on a clearing edge.
  assign w_ready = (r_state == GRANT) && !Reset && !bus.AFFull && !w_row_break &&
                   (r_burst_cnt <= BURST_LAST);
  assign w_xfer  = w_ready && w_owner_valid;

  assign w_release = !w_owner_valid || w_row_break ||
                     (w_xfer && (r_burst_cnt == BURST_LAST));
  assign w_next_ptr = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge WriteClk) begin
    // NOTE: non-blocking assignments keep every register update based on pre-edge values.
    if (Reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_last_key  <= '0;
      r_afwd      <= '0;
      r_afwen     <= 1'b0;
    end else begin
      r_afwen <= w_xfer;
      if (w_xfer) begin
        r_afwd <= w_owner_cmd;
      end
      unique case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state     <= GRANT;
            r_grant     <= w_pick_onehot;
            r_owner     <= w_pick_idx;
            r_burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            r_last_key  <= af_key(w_owner_cmd);
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (w_release) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ReqReady = r_grant & {NREQ{w_ready}};
  assign bus.Grant    = r_grant;
  assign bus.AFWD     = r_afwd;
  assign bus.AFWEn    = r_afwen;
  assign bus.Busy     = (r_state == GRANT) || r_afwen;

endmodule

// File: tb/tb_af_req_arbiter.sv
// Scoreboard bench for af_req_arbiter: per-requester command queues drive the
// handshake, expected FIFO writes and grant order are queued and checked by a monitor.
module tb_af_req_arbiter;
  import af_arb_pkg::*;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [AF_W-1:0] req_q [NREQ][$];
  logic [AF_W-1:0] exp_af[$];
  logic [NREQ-1:0] exp_grant[$];
  logic [NREQ-1:0] fire;

  af_req_arbiter_if #(.NREQ(NREQ)) bus ();

  af_req_arbiter #(
    .NREQ     (NREQ),
    .MAXBURST (4)
  ) dut (
    .WriteClk (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [AF_W-1:0] mk(input int row, input int bank, input int col,
                                         input bit rank, input bit rw);
    return {row[13:0], bank[2:0], col[7:0], rank, rw};
  endfunction

  task automatic nxt();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      nxt();
      done = (req_q[0].size() == 0) && (req_q[1].size() == 0) && (req_q[2].size() == 0) &&
             (req_q[3].size() == 0) && (exp_af.size() == 0) &&
             (bus.Grant == '0) && (bus.AFWEn == 1'b0);
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: %0d FIFO writes still outstanding, required 0", name, exp_af.size());
    end
    nxt();
    check({name, "_grants_left"}, exp_grant.size(), 0);
    check({name, "_busy_idle"}, bus.Busy, 1'b0);
  endtask

  // Requester model: present queue heads at negedge, consume what was accepted at the last edge.
  initial begin
    bus.ReqValid = '0;
    bus.ReqCmd   = '0;
    fire         = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i]) void'(req_q[i].pop_front());
        bus.ReqValid[i] = (req_q[i].size() != 0);
        bus.ReqCmd[i*AF_W +: AF_W] = (req_q[i].size() != 0) ? req_q[i][0] : '0;
      end
      #2;
      fire = bus.ReqValid & bus.ReqReady;
    end
  end

  // Monitor: FIFO writes against expected data, rising grants against expected owner order.
  initial begin
    logic [NREQ-1:0] prev_grant;
    logic [AF_W-1:0] e_af;
    logic [NREQ-1:0] e_gr;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      #3;
      if (bus.AFWEn === 1'b1) begin
        if (exp_af.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL af_unexpected: got write %h, required no write", bus.AFWD);
        end else begin
          e_af = exp_af.pop_front();
          check("af_data", bus.AFWD, e_af);
        end
      end
      if (bus.Grant != '0 && prev_grant == '0) begin
        if (exp_grant.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL grant_unexpected: got %b, required no grant", bus.Grant);
        end else begin
          e_gr = exp_grant.pop_front();
          check("grant_order", bus.Grant, e_gr);
        end
      end
      prev_grant = bus.Grant;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [AF_W-1:0] cmd, x0, x1, y;
    logic [NREQ-1:0] g_exp;
    rst        = 1'b1;
    bus.AFFull = 1'b0;
    repeat (2) nxt();
    check("rst_grant", bus.Grant, 0);
    check("rst_ready", bus.ReqReady, 0);
    check("rst_afwen", bus.AFWEn, 0);
    check("rst_afwd", bus.AFWD, 0);
    check("rst_busy", bus.Busy, 0);
    rst = 1'b0;
    nxt();

    // Single requester 2, three same-row entries with mixed rw.
    for (int c = 0; c < 3; c++) begin
      cmd = mk(16'h0012, 1, c, 1'b0, c[0]);
      req_q[2].push_back(cmd);
      exp_af.push_back(cmd);
    end
    exp_grant.push_back(4'b0100);
    nxt();
    check("t1_grant_c0", bus.Grant, 4'b0000);
    nxt();
    check("t1_grant_c1", bus.Grant, 4'b0100);
    check("t1_ready_c1", bus.ReqReady, 4'b0100);
    nxt();
    check("t1_afwen_c2", bus.AFWEn, 1'b1);
    wait_idle("t1");

    // Reset one cycle after a transfer; rrPtr is 3 beforehand, so 2 must win over 3 afterwards.
    x0 = mk(16'h0020, 2, 0, 1'b1, 1'b0);
    x1 = mk(16'h0020, 2, 1, 1'b1, 1'b1);
    y  = mk(16'h0031, 5, 7, 1'b0, 1'b0);
    req_q[2].push_back(x0);
    req_q[2].push_back(x1);
    exp_af.push_back(x0);
    exp_af.push_back(x1);
    exp_af.push_back(y);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    nxt();
    nxt();
    check("t5_grant_c1", bus.Grant, 4'b0100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_q[3].push_back(y);
    #2;
    check("t5_ready_in_reset", bus.ReqReady, 4'b0000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("t5_afwen_after_rst", bus.AFWEn, 1'b0);
    check("t5_grant_after_rst", bus.Grant, 4'b0000);
    check("t5_busy_after_rst", bus.Busy, 1'b0);
    wait_idle("t5");

    // All four valid continuously: 0,1,2,3 get 4 each, then 0 again; one idle cycle between.
    for (int r = 0; r < NREQ; r++) begin
      for (int e = 0; e < 4; e++) begin
        cmd = mk(16'h0040, r, e, 1'b0, e[0]);
        req_q[r].push_back(cmd);
        exp_af.push_back(cmd);
      end
    end
    cmd = mk(16'h0040, 0, 4, 1'b0, 1'b1);
    req_q[0].push_back(cmd);
    exp_af.push_back(cmd);
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    nxt();
    for (int c = 1; c <= 22; c++) begin
      nxt();
      if (c >= 21)          g_exp = 4'b0001;
      else if (c % 5 == 0)  g_exp = 4'b0000;
      else                  g_exp = 4'b0001 << ((c - 1) / 5);
      check($sformatf("t4_grant_c%0d", c), bus.Grant, g_exp);
    end
    wait_idle("t4");

    // Requester 1 drops after one entry; rrPtr moves to 2 so 3 beats 0.
    cmd = mk(16'h0055, 0, 1, 1'b0, 1'b0); req_q[1].push_back(cmd); exp_af.push_back(cmd);
    cmd = mk(16'h0066, 4, 2, 1'b1, 1'b1); req_q[3].push_back(cmd); exp_af.push_back(cmd);
    cmd = mk(16'h0077, 7, 3, 1'b0, 1'b0); req_q[0].push_back(cmd); exp_af.push_back(cmd);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    nxt();
    nxt();
    check("t6_grant_c1", bus.Grant, 4'b0010);
    nxt();
    check("t6_grant_c2", bus.Grant, 4'b0010);
    nxt();
    check("t6_grant_c3", bus.Grant, 4'b0000);
    nxt();
    check("t6_grant_c4", bus.Grant, 4'b1000);
    wait_idle("t6");

    // Row change on requester 1 breaks the burst; the second entry waits for a fresh grant.
    x0 = mk(16'h0012, 3, 4, 1'b1, 1'b1);
    x1 = mk(16'h0013, 3, 5, 1'b1, 1'b0);
    req_q[1].push_back(x0);
    req_q[1].push_back(x1);
    exp_af.push_back(x0);
    exp_af.push_back(x1);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0010);
    nxt();
    nxt();
    check("t2_grant_c1", bus.Grant, 4'b0010);
    check("t2_ready_c1", bus.ReqReady, 4'b0010);
    nxt();
    check("t2_grant_c2", bus.Grant, 4'b0010);
    check("t2_ready_rowbreak", bus.ReqReady, 4'b0000);
    nxt();
    check("t2_grant_c3", bus.Grant, 4'b0000);
    nxt();
    check("t2_grant_c4", bus.Grant, 4'b0010);
    check("t2_ready_c4", bus.ReqReady, 4'b0010);
    wait_idle("t2");

    // AFFull for 5 cycles after the second transfer of requester 0's burst.
    for (int c = 0; c < 4; c++) begin
      cmd = mk(16'h0100, 6, c, 1'b0, c[0]);
      req_q[0].push_back(cmd);
      exp_af.push_back(cmd);
    end
    exp_grant.push_back(4'b0001);
    nxt();
    nxt();
    nxt();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      bus.AFFull = 1'b1;
      #2;
      check($sformatf("t3_stall_grant_ready_%0d", k), {bus.Grant, bus.ReqReady}, 8'b0001_0000);
      if (k > 0) check($sformatf("t3_stall_afwen_%0d", k), bus.AFWEn, 1'b0);
    end
    @(negedge clk);
    #1;
    bus.AFFull = 1'b0;
    wait_idle("t3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
